// File: rtl/sram_pkg.sv
// Shared constants, cycle classification and read-pipe beat type for the SRAM device model.
package sram_pkg;

  localparam int SRAM_DQ_W    = 16;
  localparam int SRAM_ADDR_W  = 18;
  localparam int READ_LAT_MAX = 4;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    DESEL_OUT
  } cycle_class_t;

  typedef enum logic [1:0] {
    PERR_NONE,
    PERR_WE_OE,
    PERR_WE_DRIVE,
    PERR_UNKNOWN
  } proto_cause_t;

  typedef struct packed {
    logic                 valid;
    logic [SRAM_DQ_W-1:0] data;
    logic                 ub_n;
    logic                 lb_n;
  } rd_beat_t;

  // WE_N outranks OE_N, so a write with OE_N low still counts as a write.
  function automatic cycle_class_t classify(input logic ce_n, input logic we_n, input logic oe_n);
    if (ce_n) return IDLE;
    if (!we_n) return WRITE;
    if (!oe_n) return READ;
    return DESEL_OUT;
  endfunction

endpackage

// File: rtl/sram_read_pipe.sv
// Fixed-depth delay line carrying captured read beats from the capture register to the bus head.
module sram_read_pipe
  import sram_pkg::*;
#(
  parameter int READ_LAT = 1
) (
  input  logic     clk,
  input  logic     rst,
  input  rd_beat_t din,
  output rd_beat_t dout
);

  rd_beat_t stage_reg [READ_LAT];

  // Only the valid bits are cleared; payload bits are don't-care once invalid.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < READ_LAT; i++) begin
        stage_reg[i].valid <= 1'b0;
      end
    end else begin
      stage_reg[0] <= din;
      for (int i = 1; i < READ_LAT; i++) begin
        stage_reg[i] <= stage_reg[i-1];
      end
    end
  end

  assign dout = stage_reg[READ_LAT-1];

endmodule

// File: rtl/sram_device_model.sv
// Device-side model of a 16-bit async-style SRAM built on inferred block RAM.
// Optional protocol checker enabled by defining SRAM_PROTOCOL_CHECK_EN.
module sram_device_model
  import sram_pkg::*;
#(
  parameter int DEPTH_W   = 10,
  parameter int READ_LAT  = 1,
  parameter int INIT_ZERO = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  inout  wire  [SRAM_DQ_W-1:0]   SRAM_DQ,
  input  logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  input  logic                   SRAM_UB_N,
  input  logic                   SRAM_LB_N,
  input  logic                   SRAM_WE_N,
  input  logic                   SRAM_CE_N,
  input  logic                   SRAM_OE_N,
  output logic                   wr_strobe,
  output logic                   rd_strobe,
  output logic                   proto_err
);

  localparam int DEPTH = 1 << DEPTH_W;

  logic [SRAM_DQ_W-1:0] mem [DEPTH] = '{default: (INIT_ZERO != 0) ? 16'h0000 : 16'hxxxx};

  logic [DEPTH_W-1:0] addr;
  logic               addr_unused;
  cycle_class_t       cyc;
  rd_beat_t           cap_reg;
  rd_beat_t           head;
  logic               wr_strobe_reg;
  logic               rd_strobe_reg;
  logic [1:0]         lane_drive;

  // Upper address bits alias onto the stored range.
  assign addr        = SRAM_ADDR[DEPTH_W-1:0];
  assign addr_unused = ^SRAM_ADDR[SRAM_ADDR_W-1:DEPTH_W];
  assign cyc         = classify(SRAM_CE_N, SRAM_WE_N, SRAM_OE_N);

  always_ff @(posedge clk) begin
    if (rst && (cyc == WRITE)) begin
      if (!SRAM_UB_N) mem[addr][15:8] <= SRAM_DQ[15:8];
      if (!SRAM_LB_N) mem[addr][7:0]  <= SRAM_DQ[7:0];
    end
  end

  // Registered read of the block RAM doubles as read-pipe stage 0.
  always_ff @(posedge clk) begin
    cap_reg.data <= mem[addr];
    if (!rst) begin
      cap_reg.valid <= 1'b0;
      cap_reg.ub_n  <= 1'b1;
      cap_reg.lb_n  <= 1'b1;
      wr_strobe_reg <= 1'b0;
      rd_strobe_reg <= 1'b0;
    end else begin
      cap_reg.valid <= (cyc == READ);
      cap_reg.ub_n  <= SRAM_UB_N;
      cap_reg.lb_n  <= SRAM_LB_N;
      wr_strobe_reg <= (cyc == WRITE);
      rd_strobe_reg <= (cyc == READ);
    end
  end

  assign wr_strobe = wr_strobe_reg;
  assign rd_strobe = rd_strobe_reg;

  sram_read_pipe #(
    .READ_LAT(READ_LAT)
  ) u_read_pipe (
    .clk (clk),
    .rst (rst),
    .din (cap_reg),
    .dout(head)
  );

  // Head is driven only while the bus is still in a read cycle; otherwise it falls off the pipe.
  assign lane_drive[1] = head.valid && (cyc == READ) && !head.ub_n;
  assign lane_drive[0] = head.valid && (cyc == READ) && !head.lb_n;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
      assign SRAM_DQ[gi*8 +: 8] = lane_drive[gi] ? head.data[gi*8 +: 8] : 8'hzz;
    end
  endgenerate

`ifdef SRAM_PROTOCOL_CHECK_EN
  proto_cause_t cause_next;
  logic         proto_err_reg;

  // A write colliding with a due response counts even though WE_N has already masked the drive.
  always_comb begin
    cause_next = PERR_NONE;
    if (!SRAM_CE_N && !SRAM_WE_N) begin
      if (!SRAM_OE_N) begin
        cause_next = PERR_WE_OE;
      end else if (head.valid && (!head.ub_n || !head.lb_n)) begin
        cause_next = PERR_WE_DRIVE;
      end
`ifndef SYNTHESIS
      else if ($isunknown(SRAM_ADDR) || $isunknown(SRAM_DQ)) begin
        cause_next = PERR_UNKNOWN;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      proto_err_reg <= 1'b0;
    end else if (cause_next != PERR_NONE) begin
      proto_err_reg <= 1'b1;
    end
  end

  assign proto_err = proto_err_reg;
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_sram_device_model.sv
// Scoreboard bench: two model instances (read latency 1 and 3) on shared control pins,
// checked every cycle against a timestamped reference of the SRAM contents and due responses.
module tb_sram_device_model;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ce_n, we_n, oe_n, ub_n, lb_n, dq_en;
  logic [17:0] addr;
  logic [15:0] wdata;
  wire  [15:0] dq1, dq3;
  logic        wr_s1, rd_s1, perr1, wr_s3, rd_s3, perr3;

  assign dq1 = dq_en ? wdata : 16'hzzzz;
  assign dq3 = dq_en ? wdata : 16'hzzzz;

  sram_device_model #(.DEPTH_W(10), .READ_LAT(1), .INIT_ZERO(1)) u_lat1 (
    .clk(clk), .rst(rst), .SRAM_DQ(dq1), .SRAM_ADDR(addr), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n),
    .SRAM_WE_N(we_n), .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n),
    .wr_strobe(wr_s1), .rd_strobe(rd_s1), .proto_err(perr1)
  );

  sram_device_model #(.DEPTH_W(10), .READ_LAT(3), .INIT_ZERO(1)) u_lat3 (
    .clk(clk), .rst(rst), .SRAM_DQ(dq3), .SRAM_ADDR(addr), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n),
    .SRAM_WE_N(we_n), .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n),
    .wr_strobe(wr_s3), .rd_strobe(rd_s3), .proto_err(perr3)
  );

  typedef struct {
    int          inst;
    int          due;
    logic [15:0] data;
    logic        ub_n;
    logic        lb_n;
  } pend_t;

  typedef struct {
    int          inst;
    int          cyc;
    logic        chk_dq;
    logic [1:0]  drv;
    logic [15:0] data;
    logic        wr_s;
    logic        rd_s;
    logic        perr;
  } obs_t;

  logic [15:0] ref_mem [1024];
  pend_t       pend_q [$];
  obs_t        obs_q [$];
  int          cyc_cnt = 0;
  logic        perr_m [2] = '{1'b0, 1'b0};
  logic        head_live [2] = '{1'b0, 1'b0};
  int          n_checks = 0;
  int          n_pass = 0;

  // Reference model: what each edge should do, in terms of due times rather than pipe stages.
  always @(posedge clk) begin
    bit    is_wr, is_rd, found;
    int    a;
    pend_t p;
    obs_t  o;
    cyc_cnt++;
    is_wr = !ce_n && !we_n;
    is_rd = !ce_n && we_n && !oe_n;
    a = int'(addr) % 1024;
    if (!rst) pend_q.delete();
    for (int k = 0; k < 2; k++) begin
      found = 1'b0;
      p = '{inst: 0, due: 0, data: 16'h0, ub_n: 1'b1, lb_n: 1'b1};
      for (int j = 0; j < pend_q.size(); j++) begin
        if (pend_q[j].inst == k && pend_q[j].due == cyc_cnt) begin
          p = pend_q[j];
          pend_q.delete(j);
          found = 1'b1;
          break;
        end
      end
`ifdef SRAM_PROTOCOL_CHECK_EN
      if (!rst) perr_m[k] = 1'b0;
      else if (!ce_n && !we_n && (!oe_n || head_live[k])) perr_m[k] = 1'b1;
`endif
      head_live[k] = found && (!p.ub_n || !p.lb_n);
      o.inst   = k;
      o.cyc    = cyc_cnt;
      o.chk_dq = we_n;
      o.drv    = (found && is_rd) ? {~p.ub_n, ~p.lb_n} : 2'b00;
      o.data   = p.data;
      o.wr_s   = rst && is_wr;
      o.rd_s   = rst && is_rd;
      o.perr   = perr_m[k];
      obs_q.push_back(o);
      if (rst && is_rd)
        pend_q.push_back('{inst: k, due: cyc_cnt + ((k == 0) ? 1 : 3), data: ref_mem[a],
                           ub_n: ub_n, lb_n: lb_n});
    end
    if (rst && is_wr) begin
      if (!ub_n) ref_mem[a][15:8] = wdata[15:8];
      if (!lb_n) ref_mem[a][7:0]  = wdata[7:0];
    end
  end

  task automatic check_bit(input string nm, input int inst, input int cyc, input logic got,
                           input logic exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s inst%0d cyc %0d: got %b required %b", nm, inst, cyc, got, exp);
  endtask

  task automatic check_obs(input obs_t o);
    logic [15:0] v;
    logic [7:0]  got, exp;
    logic        ok;
    v = (o.inst == 0) ? dq1 : dq3;
    check_bit("wr_strobe", o.inst, o.cyc, (o.inst == 0) ? wr_s1 : wr_s3, o.wr_s);
    check_bit("rd_strobe", o.inst, o.cyc, (o.inst == 0) ? rd_s1 : rd_s3, o.rd_s);
    check_bit("proto_err", o.inst, o.cyc, (o.inst == 0) ? perr1 : perr3, o.perr);
    if (o.chk_dq) begin
      for (int l = 0; l < 2; l++) begin
        got = v[l*8 +: 8];
        exp = o.data[l*8 +: 8];
        n_checks++;
        if (o.drv[l]) ok = (got === exp);
        else ok = (got === 8'hzz) || (got === 8'h00);
        if (ok) n_pass++;
        else if (o.drv[l])
          $display("FAIL dq_lane%0d inst%0d cyc %0d: got %h required %h", l, o.inst, o.cyc, got, exp);
        else
          $display("FAIL dq_lane%0d inst%0d cyc %0d: got %h required released (z)", l, o.inst, o.cyc, got);
      end
      if (o.drv != 2'b00)
        $display("cyc %0d lat%0d read response lanes=%b dq=%h expected=%h", o.cyc,
                 (o.inst == 0) ? 1 : 3, o.drv, v, o.data);
    end
  endtask

  initial begin
    obs_t o;
    forever begin
      @(posedge clk);
      #1;
      while (obs_q.size() > 0) begin
        o = obs_q.pop_front();
        check_obs(o);
      end
    end
  end

  task automatic bus(input logic r, input logic ce, input logic we, input logic oe,
                     input logic ub, input logic lb, input logic [17:0] a, input logic [15:0] d);
    @(negedge clk);
    rst = r; ce_n = ce; we_n = we; oe_n = oe; ub_n = ub; lb_n = lb;
    addr = a; wdata = d; dq_en = !we;
  endtask

  task automatic wr(input logic [17:0] a, input logic [15:0] d, input logic ub, input logic lb);
    bus(1'b1, 1'b0, 1'b0, 1'b1, ub, lb, a, d);
  endtask

  task automatic rd(input logic [17:0] a);
    bus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, a, 16'h0);
  endtask

  task automatic idle();
    bus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 18'h0, 16'h0);
  endtask

  initial begin
    rst = 1'b0; ce_n = 1'b1; we_n = 1'b1; oe_n = 1'b1; ub_n = 1'b1; lb_n = 1'b1;
    addr = '0; wdata = '0; dq_en = 1'b0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 16'h0;
    repeat (3) bus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 18'h0, 16'h0);
    idle();

    // Single-word write then sustained reads to present the response.
    wr(18'h00012, 16'hBEEF, 1'b0, 1'b0);
    repeat (5) rd(18'h00012);
    idle();

    // Byte-lane merge.
    wr(18'd5, 16'h1234, 1'b0, 1'b0);
    wr(18'd5, 16'hAB00, 1'b0, 1'b1);
    repeat (5) rd(18'd5);
    idle();

    // Back-to-back reads of distinct words, also via aliased upper address bits.
    wr(18'd1, 16'h1111, 1'b0, 1'b0);
    wr(18'd2, 16'h2222, 1'b0, 1'b0);
    wr(18'h3C003, 16'h3333, 1'b0, 1'b0);
    rd(18'd1); rd(18'h10002); rd(18'd3);
    repeat (4) rd(18'd0);
    idle();

    // Write to an address with a read still in flight.
    wr(18'd7, 16'h0A0A, 1'b0, 1'b0);
    rd(18'd7);
    wr(18'd7, 16'h5555, 1'b0, 1'b0);
    rd(18'd0); rd(18'd0);
    repeat (5) rd(18'd7);
    idle();

    // Reset while a response is pending.
    rd(18'h00012);
    bus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 18'h00012, 16'h0);
    repeat (4) bus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 18'h00012, 16'h0);
    idle();

    // Simultaneous WE_N/OE_N, then reset to clear any sticky error.
    bus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 18'd9, 16'h9999);
    repeat (3) idle();
    bus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 18'h0, 16'h0);
    idle();

    for (int i = 0; i < 600; i++) begin
      bus(($urandom_range(0, 59) != 0), ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
          {8'($urandom), 10'($urandom_range(0, 15))}, 16'($urandom));
    end

    repeat (6) idle();
    @(posedge clk);
    #3;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
